// File: rtl/pdp8_uart_if.sv
// rtl/pdp8_uart_if.sv - console controller <-> serial core handshake bundle
interface pdp8_uart_if;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic       tx_empty;
  logic       rx_req;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_empty;

  modport master (
    output tx_req, tx_data, rx_req,
    input  tx_ack, tx_empty, rx_ack, rx_data, rx_empty
  );

  modport slave (
    input  tx_req, tx_data, rx_req,
    output tx_ack, tx_empty, rx_ack, rx_data, rx_empty
  );
endinterface

// File: rtl/pdp8_uart.sv
// rtl/pdp8_uart.sv - PDP-8 console 8N1 transmitter and oversampling receiver
module pdp8_uart #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_clk,
  input  logic        rx_clk,
  input  logic        rxd,
  output logic        txd,
  pdp8_uart_if.slave  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_TICK = TW'(OVERSAMPLE - 1);

  // Baud clocks and rxd are asynchronous; the third tap gives edge detection.
  logic [2:0] tx_clk_sync;
  logic [2:0] rx_clk_sync;
  logic [1:0] rxd_sync;
  logic       tx_tick;
  logic       rx_tick;
  logic       rxd_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_clk_sync <= '0;
      rx_clk_sync <= '0;
      rxd_sync    <= 2'b11;
    end else begin
      tx_clk_sync <= {tx_clk_sync[1:0], tx_clk};
      rx_clk_sync <= {rx_clk_sync[1:0], rx_clk};
      rxd_sync    <= {rxd_sync[0], rxd};
    end
  end

  assign tx_tick = tx_clk_sync[1] & ~tx_clk_sync[2];
  assign rx_tick = rx_clk_sync[1] & ~rx_clk_sync[2];
  assign rxd_s   = rxd_sync[1];

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_ACK,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  tx_state_t  tx_state, tx_state_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic [2:0] tx_bit_cnt, tx_bit_cnt_n;
  logic       txd_q, txd_n;
  logic       tx_ack_q, tx_ack_n;
  logic       tx_empty_q, tx_empty_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state   <= TX_IDLE;
      tx_shift   <= '0;
      tx_bit_cnt <= '0;
      txd_q      <= 1'b1;
      tx_ack_q   <= 1'b0;
      tx_empty_q <= 1'b1;
    end else begin
      tx_state   <= tx_state_n;
      tx_shift   <= tx_shift_n;
      tx_bit_cnt <= tx_bit_cnt_n;
      txd_q      <= txd_n;
      tx_ack_q   <= tx_ack_n;
      tx_empty_q <= tx_empty_n;
    end
  end

  // State names the bit currently on the line; ACK is loaded but not yet started.
  always_comb begin
    tx_state_n   = tx_state;
    tx_shift_n   = tx_shift;
    tx_bit_cnt_n = tx_bit_cnt;
    txd_n        = txd_q;
    tx_ack_n     = tx_ack_q;
    if (tx_ack_q && !bus.tx_req) begin
      tx_ack_n = 1'b0;
    end
    case (tx_state)
      TX_IDLE: begin
        // A still-high ack means tx_req has not dropped since the last byte.
        if (bus.tx_req && !tx_ack_q) begin
          tx_shift_n = bus.tx_data;
          tx_ack_n   = 1'b1;
          tx_state_n = TX_ACK;
        end
      end
      TX_ACK: begin
        if (tx_tick) begin
          txd_n      = 1'b0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          txd_n        = tx_shift[0];
          tx_shift_n   = {1'b0, tx_shift[7:1]};
          tx_bit_cnt_n = 3'd0;
          tx_state_n   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_bit_cnt == 3'd7) begin
            txd_n      = 1'b1;
            tx_state_n = TX_STOP;
          end else begin
            txd_n        = tx_shift[0];
            tx_shift_n   = {1'b0, tx_shift[7:1]};
            tx_bit_cnt_n = tx_bit_cnt + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_state_n = TX_IDLE;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        txd_n      = 1'b1;
      end
    endcase
    tx_empty_n = (tx_state_n == TX_IDLE) && !tx_ack_n;
  end

  assign txd          = txd_q;
  assign bus.tx_ack   = tx_ack_q;
  assign bus.tx_empty = tx_empty_q;

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t   rx_state, rx_state_n;
  logic [TW-1:0] rx_tick_cnt, rx_tick_cnt_n;
  logic [2:0]  rx_bit_cnt, rx_bit_cnt_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_frame_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state    <= RX_HUNT;
      rx_tick_cnt <= '0;
      rx_bit_cnt  <= '0;
      rx_shift    <= '0;
    end else begin
      rx_state    <= rx_state_n;
      rx_tick_cnt <= rx_tick_cnt_n;
      rx_bit_cnt  <= rx_bit_cnt_n;
      rx_shift    <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n    = rx_state;
    rx_tick_cnt_n = rx_tick_cnt;
    rx_bit_cnt_n  = rx_bit_cnt;
    rx_shift_n    = rx_shift;
    rx_frame_ok   = 1'b0;
    if (rx_tick) begin
      case (rx_state)
        RX_HUNT: begin
          if (!rxd_s) begin
            rx_tick_cnt_n = '0;
            rx_state_n    = RX_START;
          end
        end
        RX_START: begin
          // Half a bit later the line must still be low, else it was a glitch.
          if (rx_tick_cnt == HALF_TICK) begin
            rx_tick_cnt_n = '0;
            rx_bit_cnt_n  = 3'd0;
            rx_state_n    = rxd_s ? RX_HUNT : RX_DATA;
          end else begin
            rx_tick_cnt_n = rx_tick_cnt + TW'(1);
          end
        end
        RX_DATA: begin
          if (rx_tick_cnt == FULL_TICK) begin
            rx_tick_cnt_n = '0;
            rx_shift_n    = {rxd_s, rx_shift[7:1]};
            rx_bit_cnt_n  = rx_bit_cnt + 3'd1;
            if (rx_bit_cnt == 3'd7) begin
              rx_state_n = RX_STOP;
            end
          end else begin
            rx_tick_cnt_n = rx_tick_cnt + TW'(1);
          end
        end
        RX_STOP: begin
          if (rx_tick_cnt == FULL_TICK) begin
            rx_tick_cnt_n = '0;
            rx_frame_ok   = rxd_s;
            rx_state_n    = RX_HUNT;
          end else begin
            rx_tick_cnt_n = rx_tick_cnt + TW'(1);
          end
        end
        default: begin
          rx_state_n = RX_HUNT;
        end
      endcase
    end
  end

  logic [7:0] rx_hold;
  logic [7:0] rx_data_q;
  logic       rx_ack_q;
  logic       rx_empty_q;
  logic       rx_deliver;

  assign rx_deliver = bus.rx_req && !rx_empty_q && !rx_ack_q;

  // A delivery in the same cycle frees the holding register for the new byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_hold    <= '0;
      rx_data_q  <= '0;
      rx_ack_q   <= 1'b0;
      rx_empty_q <= 1'b1;
    end else begin
      if (rx_deliver) begin
        rx_data_q <= rx_hold;
        rx_ack_q  <= 1'b1;
      end else if (!bus.rx_req) begin
        rx_ack_q  <= 1'b0;
      end
      if (rx_frame_ok && (rx_empty_q || rx_deliver)) begin
        rx_hold    <= rx_shift;
        rx_empty_q <= 1'b0;
      end else if (rx_deliver) begin
        rx_empty_q <= 1'b1;
      end
    end
  end

  assign bus.rx_ack   = rx_ack_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_empty = rx_empty_q;

endmodule

// File: tb/tb_pdp8_uart.sv
// tb/tb_pdp8_uart.sv - directed bench for pdp8_uart
module tb_pdp8_uart;

  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx_clk = 1'b0;
  logic rx_clk = 1'b0;
  logic rxd = 1'b1;
  logic txd;

  int checks = 0;
  int errors = 0;

  pdp8_uart_if u_if ();

  pdp8_uart #(.OVERSAMPLE(OS)) dut (
    .clk    (clk),
    .reset  (reset),
    .tx_clk (tx_clk),
    .rx_clk (rx_clk),
    .rxd    (rxd),
    .txd    (txd),
    .bus    (u_if)
  );

  // Edges of the baud clocks never coincide with clk posedges.
  always #5   clk    = ~clk;
  always #40  rx_clk = ~rx_clk;
  always #200 tx_clk = ~tx_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tx_send(input logic [7:0] b);
    @(negedge clk);
    u_if.tx_data = b;
    u_if.tx_req  = 1'b1;
    for (int i = 0; i < 50 && !u_if.tx_ack; i++) @(negedge clk);
    check("tx_ack_rise", u_if.tx_ack, 1);
    u_if.tx_req = 1'b0;
  endtask

  // Samples each bit at its centre; tx bit period is 400 ns.
  task automatic tx_capture(output logic [9:0] fr, output logic saw_empty);
    fr = '0;
    saw_empty = 1'b0;
    for (int i = 0; i < 200 && txd; i++) @(negedge clk);
    check("tx_start_seen", txd, 0);
    #200;
    for (int i = 0; i < 10; i++) begin
      fr[i] = txd;
      if (u_if.tx_empty) saw_empty = 1'b1;
      #400;
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit, input int stop_len);
    @(posedge rx_clk);
    rxd = 1'b0;
    repeat (OS) @(posedge rx_clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (OS) @(posedge rx_clk);
    end
    rxd = stop_bit;
    repeat (stop_len) @(posedge rx_clk);
    rxd = 1'b1;
  endtask

  task automatic rx_take(output logic [7:0] d);
    @(negedge clk);
    u_if.rx_req = 1'b1;
    for (int i = 0; i < 20 && !u_if.rx_ack; i++) @(negedge clk);
    check("rx_ack_rise", u_if.rx_ack, 1);
    d = u_if.rx_data;
    check("rx_empty_after_take", u_if.rx_empty, 1);
    u_if.rx_req = 1'b0;
    @(posedge clk);
    #1;
    check("rx_ack_fall", u_if.rx_ack, 0);
  endtask

  logic [9:0] frame;
  logic       saw_empty;
  logic       stayed_high;
  logic [7:0] got_byte;

  initial begin
    u_if.tx_req  = 1'b0;
    u_if.tx_data = 8'h00;
    u_if.rx_req  = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_tx_ack", u_if.tx_ack, 0);
    check("rst_tx_empty", u_if.tx_empty, 1);
    check("rst_rx_ack", u_if.rx_ack, 0);
    check("rst_rx_empty", u_if.rx_empty, 1);
    check("rst_rx_data", u_if.rx_data, 8'h00);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // Reset in the middle of data bit 3 of 0xA5
    tx_send(8'hA5);
    for (int i = 0; i < 200 && txd; i++) @(negedge clk);
    check("rmf_start_seen", txd, 0);
    #(200 + 4 * 400);
    reset = 1'b0;
    #1;
    check("rmf_txd", txd, 1);
    check("rmf_tx_empty", u_if.tx_empty, 1);
    check("rmf_tx_ack", u_if.tx_ack, 0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);

    // 0x41 -> 0,1,0,0,0,0,0,1,0,1
    tx_send(8'h41);
    tx_capture(frame, saw_empty);
    check("tx41_frame", frame, 10'h282);
    check("tx41_busy", saw_empty, 0);
    check("tx41_empty_after", u_if.tx_empty, 1);

    // tx_req held high across the frame sends only one byte
    @(negedge clk);
    u_if.tx_data = 8'h5A;
    u_if.tx_req  = 1'b1;
    for (int i = 0; i < 50 && !u_if.tx_ack; i++) @(negedge clk);
    check("b2b_ack", u_if.tx_ack, 1);
    tx_capture(frame, saw_empty);
    check("b2b_frame1", frame, 10'h2B4);
    stayed_high = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (!txd) stayed_high = 1'b0;
    end
    check("b2b_no_resend", stayed_high, 1);
    check("b2b_ack_held", u_if.tx_ack, 1);
    u_if.tx_req = 1'b0;
    for (int i = 0; i < 10 && u_if.tx_ack; i++) @(negedge clk);
    check("b2b_ack_fall", u_if.tx_ack, 0);
    check("b2b_empty", u_if.tx_empty, 1);
    tx_send(8'hC3);
    tx_capture(frame, saw_empty);
    check("b2b_frame2", frame, 10'h386);
    check("b2b_empty_after", u_if.tx_empty, 1);

    // Receive 0x0D
    rx_send(8'h0D, 1'b1, OS);
    @(negedge clk);
    check("rx0d_empty_low", u_if.rx_empty, 0);
    rx_take(got_byte);
    check("rx0d_data", got_byte, 8'h0D);

    // Framing error: stop bit low is discarded
    rx_send(8'h55, 1'b0, 10);
    repeat (40 * 8) @(negedge clk);
    check("ferr_empty", u_if.rx_empty, 1);

    // 4-tick glitch never starts a frame
    @(posedge rx_clk);
    rxd = 1'b0;
    repeat (4) @(posedge rx_clk);
    rxd = 1'b1;
    repeat (40) @(posedge rx_clk);
    @(negedge clk);
    check("glitch_empty", u_if.rx_empty, 1);

    // Overrun keeps the first byte
    rx_send(8'h31, 1'b1, OS);
    rx_send(8'h32, 1'b1, OS);
    repeat (20) @(negedge clk);
    check("ovr_empty_low", u_if.rx_empty, 0);
    rx_take(got_byte);
    check("ovr_data", got_byte, 8'h31);
    repeat (20) @(negedge clk);
    check("ovr_empty_after", u_if.rx_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdp8_uart.md
# pdp8_uart

Serial line core for the PDP-8 console terminal: an 8N1 transmitter and a 16x-oversampling receiver. Both connect to the console controller through level req/ack handshakes with empty flags. It sits directly downstream of the console controller, between that controller's tto/tti state machines and the physical txd/rxd pins. Baud timing comes from the baud-rate generator's tx_clk/rx_clk outputs, which this block synchronizes into the single clk domain.

## Interface
- OVERSAMPLE, 16: rx_clk ticks per bit period; power of two, ≥8.
- clk  in  1  system clock; all state is on the posedge.
- reset  in  1  asynchronous, active-low reset.
- tx_clk  in  1  1x baud clock from the baud-rate generator; asynchronous to clk.
- tx_req  in  1  level request to load tx_data.
- tx_data  in  8  byte to send; sampled on acceptance.
- tx_ack  out  1  acceptance acknowledge.
- tx_empty  out  1  high when the transmitter is idle with nothing pending.
- rx_clk  in  1  OVERSAMPLE×baud clock; asynchronous to clk.
- rx_req  in  1  level request to take the received byte.
- rx_ack  out  1  receive acknowledge.
- rx_data  out  8  last byte delivered; stable between deliveries.
- rx_empty  out  1  low while a received byte is waiting in the holding register.
- rxd  in  1  serial input; idle high.
- txd  out  1  serial output; idle high.

## Operation
- Tick generation:
  - tx_clk, rx_clk and rxd each pass through a 2-flop synchronizer.
  - A rising edge of the synchronized tx_clk or rx_clk produces a 1-cycle tx_tick or rx_tick.
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1). No parity.
- Transmit FSM: IDLE → ACK → START → DATA → STOP → IDLE.
  - IDLE with tx_req=1: latch tx_data into the shift register, set tx_ack=1 and tx_empty=0, go to ACK.
  - ACK: tx_ack stays high until tx_req=0, then drops.
  - Serialization does not wait for tx_req to fall. The first tx_tick after acceptance drives txd=0 (START).
  - Each later tx_tick advances one bit: 8 DATA ticks using a 3-bit counter, then one STOP tick with txd=1.
  - The tx_tick after STOP returns to IDLE. tx_empty rises when IDLE is reached and tx_ack=0.
  - tx_req while not IDLE is ignored. No second acceptance happens until IDLE, and until tx_req has been seen low since the previous ack.
- Receive FSM: HUNT → START → DATA → STOP → HUNT.
  - HUNT: synchronized rxd=0 on an rx_tick → START, tick counter cleared.
  - START: at tick OVERSAMPLE/2, rxd must still be 0, otherwise return to HUNT (glitch rejection).
  - DATA: sample once every OVERSAMPLE ticks at bit centre, shift in LSB first, 8 bits.
  - STOP: sample at centre. rxd=1 means a valid frame; rxd=0 is a framing error and the byte is discarded.
  - Valid frame with the holding register empty: load the holding register, rx_empty=0.
  - Valid frame with the holding register full (overrun): the new byte is discarded and the held byte is kept.
  - The FSM returns to HUNT right after the stop-bit sample.
- Receive handshake:
  - rx_req=1 while rx_empty=0: copy holding → rx_data, set rx_ack=1, set rx_empty=1.
  - rx_ack drops on the first cycle rx_req=0.
  - rx_req while rx_empty=1 and rx_ack=0 is ignored.
- Reset (asynchronous, any state):
  - Outputs: txd=1, tx_ack=0, tx_empty=1, rx_ack=0, rx_empty=1, rx_data=0.
  - Both FSMs return to IDLE/HUNT and all counters clear.
  - A frame in flight is abandoned. txd returns high immediately.

## Timing
- Tick latency: a tx_clk/rx_clk edge produces its tick 3 clk cycles later. Ticks require clk ≥4× the rx_clk frequency.
- tx_ack: rises the cycle after tx_req is first seen high in IDLE; falls the cycle after tx_req is seen low.
- txd transitions are registered: one clk after the tx_tick.
- Frame length: exactly 10 tx_tick periods from the start-bit edge to the end of the stop bit.
- rx_empty falls the clk after the stop-bit sample.
- rx_ack and rx_data update on the same edge, 1 cycle after rx_req is seen.
- Simultaneous stop-bit load and rx_req on the same cycle: the handshake acts on the old register state. The new byte loads because the register is then empty.

## Test plan
- Reset mid-frame:
  - Stimulus: reset=0 during DATA bit 3 of a transmission.
  - Response: txd=1 within 1 cycle, tx_empty=1, tx_ack=0. After release, the next tx_req sends a clean frame.
- Transmit 0x41:
  - Stimulus: pulse tx_req until tx_ack.
  - Response: txd carries 0,1,0,0,0,0,0,1,0,1 on successive tx_ticks. tx_empty=0 throughout, =1 after the stop bit.
- Receive 0x0D at 16x:
  - Response: rx_empty falls after the stop sample.
  - Then rx_req → rx_ack=1, rx_data=0x0D, rx_empty=1. rx_ack=0 one cycle after rx_req drops.
- Framing error and glitch rejection:
  - Frame 0x55 with stop bit 0 → rx_empty stays 1.
  - A 4-tick low pulse on rxd → no frame starts.
- Overrun:
  - Receive 0x31, then 0x32, without issuing rx_req.
  - Response: rx_req delivers 0x31. rx_empty=1 afterwards.
- Back-to-back transmit:
  - Hold tx_req high across the frame.
  - Response: only one byte is sent. A second byte is accepted only after tx_req drops and rises again in IDLE.
